mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 9, word-address width of the internal array (2^DEPTH_LOG2 x 32-bit words).
REQ-002 Parameter: DATA_W, default 32, data word width.
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: rd_req  in  1  read request; sampled on any edge in IDLE.
REQ-006 Port: wr_req  in  1  write request; sampled on any edge in IDLE.
REQ-007 Port: addr  in  32  word address, driven from MAR.
REQ-008 Port: wr_data  in  DATA_W  write data, driven from MDR.
REQ-009 Port: rd_data  out  DATA_W  registered read data; holds its value until the next read response.
REQ-010 Port: rd_valid  out  1  one-cycle pulse; rd_data is valid in that cycle.
REQ-011 Port: busy  out  1  high whenever state is not IDLE.
REQ-012 Port: err  out  1  one-cycle error pulse.

Function
REQ-013 FSM states SHALL be IDLE, RD, WAIT, RESP and WR.
REQ-014 IDLE SHALL go to RD on rd_req and to WR on wr_req (rd_req=0), latching addr and wr_data on that edge.
REQ-015 rd_req and wr_req high together SHALL be treated as a read; the write is dropped and err pulses in the RESP cycle.
REQ-016 RD SHALL register array[addr[DEPTH_LOG2-1:0]] into an internal buffer and go to RESP (or WAIT, per REQ-027).
REQ-017 RESP SHALL drive rd_data from the buffer, assert rd_valid for exactly one cycle, and return to IDLE.
REQ-018 WR SHALL write the latched data to the array on the edge leaving WR, then return to IDLE; no response pulse is generated.
REQ-019 Read latency: with rd_req sampled at edge N, rd_valid SHALL be high in the cycle after edge N+2.
REQ-020 Write latency: with wr_req sampled at edge N, the array SHALL be updated at edge N+1; a read accepted at edge N+2 returns the new data.
REQ-021 Requests while busy=1 SHALL be ignored and not queued.
REQ-022 Out-of-range addresses (addr[31:DEPTH_LOG2] != 0) SHALL NOT be written; a read returns 0 with err high alongside rd_valid; a write pulses err in the cycle after WR.
REQ-023 Back-to-back accesses: a new request is accepted on the first edge where the state is IDLE.

Reset
REQ-024 On reset, state SHALL be IDLE, and rd_data=0, rd_valid=0, busy=0, err=0 at the next edge.
REQ-025 Reset SHALL take priority over all transitions; a reset in WR SHALL suppress the pending write, and a reset in RD/WAIT/RESP SHALL suppress rd_valid.
REQ-026 Reset SHALL NOT clear array contents.

Configuration
REQ-027 Macro MEM_RESPONDER_WAIT_EN: when defined, RD SHALL go to WAIT and WAIT to RESP, adding one cycle of read latency (rd_valid in the cycle after edge N+3); when undefined, the WAIT state is not built and RD goes directly to RESP.

Verification
REQ-028 Write 0xDEADBEEF to addr 5, then read addr 5 -> rd_valid one cycle, rd_data=0xDEADBEEF, latency per REQ-019 (or REQ-027 when the macro is defined).
REQ-029 rd_req and wr_req both high, addr 7 preloaded with 0x11 -> rd_data=0x11, err=1 with rd_valid, addr 7 still 0x11 afterwards.
REQ-030 Read addr 0x200 (DEPTH_LOG2=9) -> rd_data=0, err=1; write 0x55 to 0x200 -> err pulse, addr 0 unchanged.
REQ-031 Pulse wr_req while busy during a read -> request dropped, array unchanged, busy deasserts on return to IDLE.
REQ-032 Assert reset in the WR cycle for addr 3 (old value 0xA) -> addr 3 still 0xA, all outputs 0 after the reset edge.
REQ-033 Write 0x1 to addr 9, then read addr 9 accepted at edge N+2 -> rd_data=0x1 (no stale data).

Source files
------------

// File: rtl/mem_responder.sv
// Single-port word memory behind a request/response FSM (IDLE, RD, [WAIT], RESP, WR).
// Define MEM_RESPONDER_WAIT_EN to add a WAIT state and one extra cycle of read latency.
module mem_responder #(
  parameter int DEPTH_LOG2 = 9,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_req,
  input  logic              wr_req,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              err,
  output logic [2:0]        dbg_state
);

  // Handshake: rd_req/wr_req are level-sampled only on edges where the FSM is IDLE
  // (busy=0); anything seen while busy=1 is dropped. A read completes with a one-cycle
  // rd_valid pulse; a write completes silently unless its address is out of range.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RESP = 3'd2,
`ifdef MEM_RESPONDER_WAIT_EN
    WAIT = 3'd4,
`endif
    WR   = 3'd3
  } state_t;

  state_t              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                dual_q, dual_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   buf_q;
  logic                mem_we;
  logic                oor;
  logic [DEPTH_LOG2-1:0] idx;

  logic [DATA_W-1:0] mem_q [2**DEPTH_LOG2];

  assign oor = |addr_q[31:DEPTH_LOG2];
  assign idx = addr_q[DEPTH_LOG2-1:0];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    dual_d     = dual_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    err_d      = 1'b0;
    mem_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          state_d = RD;
          addr_d  = addr;
          dual_d  = wr_req;
        end else if (wr_req) begin
          state_d = WR;
          addr_d  = addr;
          wdata_d = wr_data;
          dual_d  = 1'b0;
        end
      end
`ifdef MEM_RESPONDER_WAIT_EN
      RD:   state_d = WAIT;
      WAIT: state_d = RESP;
`else
      RD:   state_d = RESP;
`endif
      RESP: begin
        rd_data_d  = buf_q;
        rd_valid_d = 1'b1;
        // A simultaneous write request was dropped in favour of the read.
        err_d      = dual_q | oor;
        state_d    = IDLE;
      end
      WR: begin
        mem_we  = ~oor;
        err_d   = oor;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      dual_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      dual_q     <= dual_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  // Array contents survive reset; only the pending write is cancelled.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) begin
      mem_q[idx] <= wdata_q;
    end
    if (state_q == RD) begin
      buf_q <= oor ? '0 : mem_q[idx];
    end
  end

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed and randomized bench for mem_responder against an associative-array memory model.
module tb_mem_responder;

  localparam int DEPTH_LOG2 = 9;
  localparam int DATA_W     = 32;
`ifdef MEM_RESPONDER_WAIT_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        rd_req;
  logic        wr_req;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        err;
  logic [2:0]  dbg_state;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] model [int];
  int          wr_addrs [$];
  logic [31:0] exp_q [$];

  mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .err(err), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
    end
  endtask

  function automatic logic is_oor(input logic [31:0] a);
    return (a >> DEPTH_LOG2) != 0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (is_oor(a)) return 32'h0;
    return model[int'(a)];
  endfunction

  // Drive a read request; returns just after the accepting edge.
  task automatic issue_read(input logic [31:0] a);
    @(negedge clk);
    rd_req = 1'b1;
    wr_req = 1'b0;
    addr   = a;
    @(posedge clk);
    exp_q.push_back(model_read(a));
  endtask

  // Wait for the response; k_start is the number of post-accept cycles already consumed.
  task automatic read_response(input string tag, input int k_start, input logic exp_err);
    int k;
    bit seen;
    logic [31:0] e;
    e = exp_q.pop_front();
    k = k_start;
    seen = 1'b0;
    while (k < 12 && !seen) begin
      @(negedge clk);
      rd_req = 1'b0;
      wr_req = 1'b0;
      if (rd_valid === 1'b1) seen = 1'b1;
      else begin
        if (k < LAT) check({tag, " busy_during"}, {31'b0, busy}, 32'h1);
        k++;
      end
    end
    check({tag, " latency"}, 32'(k), 32'(LAT));
    if (seen) begin
      check({tag, " data"}, rd_data, e);
      check({tag, " err"}, {31'b0, err}, {31'b0, exp_err});
      @(negedge clk);
      check({tag, " valid_pulse"}, {31'b0, rd_valid}, 32'h0);
      check({tag, " busy_after"}, {31'b0, busy}, 32'h0);
      check({tag, " data_hold"}, rd_data, e);
      check({tag, " err_pulse"}, {31'b0, err}, 32'h0);
    end
  endtask

  task automatic do_read(input string tag, input logic [31:0] a);
    issue_read(a);
    read_response(tag, 0, is_oor(a));
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_req  = 1'b1;
    rd_req  = 1'b0;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0;
    check({tag, " wr_busy"}, {31'b0, busy}, 32'h1);
    check({tag, " wr_valid"}, {31'b0, rd_valid}, 32'h0);
    @(negedge clk);
    check({tag, " wr_idle"}, {31'b0, busy}, 32'h0);
    check({tag, " wr_err"}, {31'b0, err}, {31'b0, is_oor(a)});
    if (!is_oor(a)) begin
      if (!model.exists(int'(a))) wr_addrs.push_back(int'(a));
      model[int'(a)] = d;
    end
    @(negedge clk);
    check({tag, " wr_err_pulse"}, {31'b0, err}, 32'h0);
  endtask

  initial begin : main
    logic [31:0] a;
    logic [31:0] d;
    reset = 1'b1; rd_req = 1'b0; wr_req = 1'b0; addr = '0; wr_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset rd_data", rd_data, 32'h0);
    check("reset rd_valid", {31'b0, rd_valid}, 32'h0);
    check("reset busy", {31'b0, busy}, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    reset = 1'b0;

    // Basic write then read
    do_write("w5", 32'd5, 32'hDEADBEEF);
    do_read("r5", 32'd5);

    // Simultaneous read and write: read wins, write dropped
    do_write("w7", 32'd7, 32'h11);
    @(negedge clk);
    rd_req = 1'b1; wr_req = 1'b1; addr = 32'd7; wr_data = 32'h99;
    @(posedge clk);
    exp_q.push_back(model_read(32'd7));
    read_response("dual", 0, 1'b1);
    do_read("r7_after_dual", 32'd7);

    // Out-of-range read and write
    do_write("w0", 32'd0, 32'h12345678);
    do_read("r_oor", 32'h200);
    do_write("w_oor", 32'h200, 32'h55);
    do_read("r0_after_oor", 32'd0);

    // Write request pulsed while a read is in flight
    do_write("w12", 32'd12, 32'hCAFE0012);
    issue_read(32'd5);
    @(negedge clk);
    wr_req = 1'b1; addr = 32'd12; wr_data = 32'h77;
    check("busy_wr busy", {31'b0, busy}, 32'h1);
    read_response("busy_rd", 1, 1'b0);
    do_read("r12_unchanged", 32'd12);

    // Reset during WR cancels the write
    do_write("w3", 32'd3, 32'hA);
    @(negedge clk);
    wr_req = 1'b1; addr = 32'd3; wr_data = 32'hBEEF;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0; reset = 1'b1;
    @(negedge clk);
    check("rst_wr rd_data", rd_data, 32'h0);
    check("rst_wr rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_wr busy", {31'b0, busy}, 32'h0);
    check("rst_wr err", {31'b0, err}, 32'h0);
    reset = 1'b0;
    do_read("r3_after_rst", 32'd3);

    // Reset during the read response path suppresses rd_valid
    @(negedge clk);
    rd_req = 1'b1; addr = 32'd5;
    @(posedge clk);
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_rd rd_valid", {31'b0, rd_valid}, 32'h0);
    check("rst_rd rd_data", rd_data, 32'h0);
    check("rst_rd busy", {31'b0, busy}, 32'h0);
    repeat (LAT + 1) begin
      @(negedge clk);
      check("rst_rd no_valid", {31'b0, rd_valid}, 32'h0);
    end

    // Back-to-back: write addr 9, read held so it is accepted at the first IDLE edge
    @(negedge clk);
    wr_req = 1'b1; rd_req = 1'b0; addr = 32'd9; wr_data = 32'h1;
    @(posedge clk);
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b1;
    if (!model.exists(9)) wr_addrs.push_back(9);
    model[9] = 32'h1;
    @(posedge clk);
    @(posedge clk);
    exp_q.push_back(model_read(32'd9));
    read_response("b2b r9", 0, 1'b0);

    // Randomized mix of reads and writes
    for (int i = 0; i < 40; i++) begin
      int op;
      op = int'($urandom_range(0, 2));
      if (op == 0 || wr_addrs.size() == 0) begin
        a = ($urandom_range(0, 7) == 0) ? (32'h200 + 32'($urandom_range(0, 1000)))
                                        : 32'($urandom_range(0, 31));
        d = $urandom;
        do_write("rand_w", a, d);
      end else if (op == 1) begin
        a = 32'(wr_addrs[$urandom_range(0, wr_addrs.size() - 1)]);
        do_read("rand_r", a);
      end else begin
        a = $urandom | 32'h200;
        do_read("rand_r_oor", a);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
